// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and its picker.
package dmem_arb_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Default number of memory words.
    localparam int DEPTH_DEFAULT = 32;

    // Port identifiers, also used as the last-winner pointer encoding.
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    // Collapse a one-hot two-way grant into a port id (P0 when nothing is granted).
    function automatic logic gnt_to_id(input logic [1:0] gnt);
        logic id;
        if (gnt[1]) begin
            id = P1;
        end else begin
            id = P0;
        end
        return id;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way picker: single requester wins, ties go to the port
// that did not win last time, or always to port 0 under fixed priority.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_fixed_prio,
    output logic [1:0] o_gnt
);

    // One-hot winner selection from the request vector and the last winner.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01: o_gnt = 2'b01;
            2'b10: o_gnt = 2'b10;
            2'b11: begin
                if (i_fixed_prio || (i_last == P1)) begin
                    o_gnt = 2'b01;
                end else begin
                    o_gnt = 2'b10;
                end
            end
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the core's data memory.
// Each access takes IDLE (grant) -> ACCESS (memory cycle) -> RESP (RVALID).
// Memory-side outputs come only from registers; GNT is combinational.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEFAULT,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_a,
    output logic [DATA_W-1:0] o_mem_wd,
    input  logic [DATA_W-1:0] i_mem_rd
);

    // True when a word index addresses a real memory location.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (addr < ADDR_W'(DEPTH));
    endfunction

    state_e              r_state;
    state_e              w_next_state;
    logic                r_last;
    logic                r_cmd_we;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [DATA_W-1:0]   r_cmd_wdata;
    logic                r_cmd_owner;
    logic                r_mem_we;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_arb_en;
    logic [1:0]          w_req;
    logic [1:0]          w_gnt;
    logic                w_grant;
    logic                w_win_id;
    logic                w_win_we;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic                w_cmd_in_range;

    // Requests are only visible to the picker while idle and out of reset,
    // so GNT drops immediately when reset is asserted.
    always_comb begin
        w_arb_en = 1'b0;
        w_req    = 2'b00;
        if ((r_state == IDLE) && i_rst_n) begin
            w_arb_en = 1'b1;
        end else begin
            w_arb_en = 1'b0;
        end
        w_req = {i_req1, i_req0} & {2{w_arb_en}};
    end

    rr_arb2 u_rr_arb2 (
        .i_req        (w_req),
        .i_last       (r_last),
        .i_fixed_prio (1'(FIXED_PRIO)),
        .o_gnt        (w_gnt)
    );

    // Route the winning port's command fields toward the command register.
    always_comb begin
        w_grant     = |w_gnt;
        w_win_id    = gnt_to_id(w_gnt);
        w_win_we    = 1'b0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        if (w_win_id == P1) begin
            w_win_we    = i_we1;
            w_win_addr  = i_addr1;
            w_win_wdata = i_wdata1;
        end else begin
            w_win_we    = i_we0;
            w_win_addr  = i_addr0;
            w_win_wdata = i_wdata0;
        end
    end

    // Range check of the latched command, used during the memory cycle.
    always_comb begin
        w_cmd_in_range = addr_in_range(r_cmd_addr);
    end

    // Sequencer state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a grant starts an access, which always runs to RESP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next_state = ACCESS;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ACCESS:  w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Last-winner pointer; reset to port 1 so port 0 takes the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= P1;
        end else if (w_grant) begin
            r_last <= w_win_id;
        end else begin
            r_last <= r_last;
        end
    end

    // Command register: captures the winner's request on the grant edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_cmd_owner <= P0;
        end else if (w_grant) begin
            r_cmd_we    <= w_win_we;
            r_cmd_addr  <= w_win_addr;
            r_cmd_wdata <= w_win_wdata;
            r_cmd_owner <= w_win_id;
        end else begin
            r_cmd_we    <= r_cmd_we;
            r_cmd_addr  <= r_cmd_addr;
            r_cmd_wdata <= r_cmd_wdata;
            r_cmd_owner <= r_cmd_owner;
        end
    end

    // Memory write enable: high for exactly the ACCESS cycle of an in-range write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_we <= 1'b0;
        end else begin
            r_mem_we <= w_grant & w_win_we & addr_in_range(w_win_addr);
        end
    end

    // Response data: sample memory at the end of ACCESS; writes and
    // out-of-range accesses return zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == ACCESS) begin
            if (!r_cmd_we && w_cmd_in_range) begin
                r_rdata <= i_mem_rd;
            end else begin
                r_rdata <= '0;
            end
            r_err <= ~w_cmd_in_range;
        end else begin
            r_rdata <= r_rdata;
            r_err   <= r_err;
        end
    end

    // Completion pulses: one cycle in RESP, steered to the command owner.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= (r_state == ACCESS) && (r_cmd_owner == P0);
            r_rvalid1 <= (r_state == ACCESS) && (r_cmd_owner == P1);
        end
    end

    assign o_gnt0    = w_gnt[0];
    assign o_gnt1    = w_gnt[1];
    assign o_rvalid0 = r_rvalid0;
    assign o_rvalid1 = r_rvalid1;
    assign o_rdata   = r_rdata;
    assign o_err     = r_err;
    assign o_mem_we  = r_mem_we;
    assign o_mem_a   = r_cmd_addr;
    assign o_mem_wd  = r_cmd_wdata;

endmodule
